icap_ctrl: RTL and testbench

ICAP_CTRL -- requirements
Module: icap_ctrl

---
 rtl/icap_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_icap_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icap_ctrl.sv
// ICAP register access sequencer: wraps one config-register read or write in
// the sync / Type-1 header / NOOP / desync word sequence expected by the ICAP.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// SYNC    | dummy + sync words, then NOOP
// HDR     | Type-1 header for the target register
// DATA    | write payload
// NOOP    | NOOP_CNT pad words after the packet
// RD_SW   | ICAP idle for one cycle while it turns to read direction
// RD_WAIT | reading; wait for busy low or timeout
// RD_END  | ICAP idle for one cycle while it turns back to write direction
// DESYNC  | CMD=DESYNC packet plus trailing NOOPs
// DONE    | one-cycle completion pulse
module icap_ctrl #(
    parameter int NOOP_CNT   = 2,
    parameter int RD_TIMEOUT = 255,
    parameter bit BIT_SWAP   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [5:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        icap_ce_n,
    output logic        icap_write_n,
    output logic [15:0] icap_i,
    input  logic [15:0] icap_o,
    input  logic        icap_busy
);

    typedef enum logic [3:0] {
        IDLE, SYNC, HDR, DATA, NOOP, RD_SW, RD_WAIT, RD_END, DESYNC, DONE
    } state_t;

    localparam logic [3:0]  NOOP_LD = 4'(NOOP_CNT - 1);
    localparam logic [15:0] TO_LD   = 16'(RD_TIMEOUT - 1);
    localparam logic [15:0] W_NOOP  = 16'h2000;

    state_t      state;
    logic [1:0]  idx;
    logic [3:0]  ncnt;
    logic [15:0] tcnt;
    logic        rd_first;
    logic        op_write;
    logic [5:0]  op_addr;
    logic [15:0] op_data;

    // Byte-wise bit reversal is its own inverse, so it serves both directions.
    function automatic logic [15:0] swap(input logic [15:0] w);
        logic [15:0] r;
        r = w;
        if (BIT_SWAP) begin
            for (int i = 0; i < 8; i++) begin
                r[i]     = w[7-i];
                r[8+i]   = w[15-i];
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] sync_word(input logic [1:0] i);
        case (i)
            2'd0:    return 16'hFFFF;
            2'd1:    return 16'hAA99;
            2'd2:    return 16'h5566;
            default: return W_NOOP;
        endcase
    endfunction

    function automatic logic [15:0] desync_word(input logic [1:0] i);
        case (i)
            2'd0:    return 16'h30A1;
            2'd1:    return 16'h000D;
            default: return W_NOOP;
        endcase
    endfunction

    assign cmd_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= 2'd0;
            ncnt         <= 4'd0;
            tcnt         <= 16'd0;
            rd_first     <= 1'b0;
            op_write     <= 1'b0;
            op_addr      <= 6'd0;
            op_data      <= 16'd0;
            icap_ce_n    <= 1'b1;
            icap_write_n <= 1'b0;
            icap_i       <= 16'd0;
            rsp_valid    <= 1'b0;
            rsp_data     <= 16'd0;
            rsp_err      <= 1'b0;
        end else begin
            // Idle bus unless the branch below issues a word.
            icap_ce_n    <= 1'b1;
            icap_write_n <= 1'b0;
            icap_i       <= 16'd0;
            rsp_valid    <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_write  <= cmd_write;
                        op_addr   <= cmd_addr;
                        op_data   <= cmd_data;
                        rsp_data  <= 16'd0;
                        rsp_err   <= 1'b0;
                        idx       <= 2'd0;
                        state     <= SYNC;
                        icap_ce_n <= 1'b0;
                        icap_i    <= swap(sync_word(2'd0));
                    end
                end
                SYNC: begin
                    icap_ce_n <= 1'b0;
                    if (idx == 2'd3) begin
                        state  <= HDR;
                        icap_i <= swap((op_write ? 16'h3001 : 16'h2801) | {5'b0, op_addr, 5'b0});
                    end else begin
                        idx    <= idx + 2'd1;
                        icap_i <= swap(sync_word(idx + 2'd1));
                    end
                end
                HDR: begin
                    icap_ce_n <= 1'b0;
                    if (op_write) begin
                        state  <= DATA;
                        icap_i <= swap(op_data);
                    end else begin
                        state  <= NOOP;
                        ncnt   <= NOOP_LD;
                        icap_i <= swap(W_NOOP);
                    end
                end
                DATA: begin
                    state     <= NOOP;
                    ncnt      <= NOOP_LD;
                    icap_ce_n <= 1'b0;
                    icap_i    <= swap(W_NOOP);
                end
                NOOP: begin
                    if (ncnt != 4'd0) begin
                        ncnt      <= ncnt - 4'd1;
                        icap_ce_n <= 1'b0;
                        icap_i    <= swap(W_NOOP);
                    end else if (op_write) begin
                        state     <= DESYNC;
                        idx       <= 2'd0;
                        icap_ce_n <= 1'b0;
                        icap_i    <= swap(desync_word(2'd0));
                    end else begin
                        state        <= RD_SW;
                        icap_write_n <= 1'b1;
                    end
                end
                RD_SW: begin
                    state        <= RD_WAIT;
                    rd_first     <= 1'b1;
                    tcnt         <= TO_LD;
                    icap_ce_n    <= 1'b0;
                    icap_write_n <= 1'b1;
                end
                RD_WAIT: begin
                    icap_write_n <= 1'b1;
                    if (!rd_first && !icap_busy) begin
                        rsp_data <= swap(icap_o);
                        state    <= RD_END;
                    end else if (tcnt == 16'd0) begin
                        rsp_err  <= 1'b1;
                        rsp_data <= 16'd0;
                        state    <= RD_END;
                    end else begin
                        tcnt      <= tcnt - 16'd1;
                        rd_first  <= 1'b0;
                        icap_ce_n <= 1'b0;
                    end
                end
                RD_END: begin
                    state     <= DESYNC;
                    idx       <= 2'd0;
                    icap_ce_n <= 1'b0;
                    icap_i    <= swap(desync_word(2'd0));
                end
                DESYNC: begin
                    if (idx == 2'd3) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                    end else begin
                        idx       <= idx + 2'd1;
                        icap_ce_n <= 1'b0;
                        icap_i    <= swap(desync_word(idx + 2'd1));
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icap_ctrl.sv
// Scoreboard bench for icap_ctrl: two instances (no swap / swap) share stimulus,
// one monitor checks the selected instance against queued expectations.
module tb_icap_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cmd_valid, cmd_write, sel;
    logic [5:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic [15:0] icap_o;
    logic        icap_busy;

    logic        ready0, rv0, err0, ce0, wn0;
    logic [15:0] rd0, ii0;
    logic        ready1, rv1, err1, ce1, wn1;
    logic [15:0] rd1, ii1;

    icap_ctrl #(.NOOP_CNT(2), .RD_TIMEOUT(8), .BIT_SWAP(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid & ~sel), .cmd_ready(ready0),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rv0), .rsp_data(rd0), .rsp_err(err0),
        .icap_ce_n(ce0), .icap_write_n(wn0), .icap_i(ii0),
        .icap_o(icap_o), .icap_busy(icap_busy));

    icap_ctrl #(.NOOP_CNT(2), .RD_TIMEOUT(255), .BIT_SWAP(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid & sel), .cmd_ready(ready1),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rv1), .rsp_data(rd1), .rsp_err(err1),
        .icap_ce_n(ce1), .icap_write_n(wn1), .icap_i(ii1),
        .icap_o(icap_o), .icap_busy(icap_busy));

    logic        m_ready, m_rv, m_err, m_ce_n, m_wr_n;
    logic [15:0] m_rd, m_i;
    assign m_ready = sel ? ready1 : ready0;
    assign m_rv    = sel ? rv1    : rv0;
    assign m_err   = sel ? err1   : err0;
    assign m_ce_n  = sel ? ce1    : ce0;
    assign m_wr_n  = sel ? wn1    : wn0;
    assign m_rd    = sel ? rd1    : rd0;
    assign m_i     = sel ? ii1    : ii0;

    // ICAP read model: busy drops on RD_WAIT cycle busy_low_at (0 = never)
    int          busy_low_at = 0;
    logic [15:0] rd_value = 16'h0;
    int          wcnt = 0;
    always @(posedge clk) wcnt <= (!m_ce_n && m_wr_n) ? wcnt + 1 : 0;
    assign icap_busy = (busy_low_at == 0) || (wcnt + 1 < busy_low_at);
    assign icap_o    = icap_busy ? 16'hDEAD : rd_value;

    typedef struct {
        logic [15:0] d;
        logic        e;
        int          lat;
    } rsp_t;

    logic [15:0] exp_w[$];
    int          exp_wait[$];
    rsp_t        exp_r[$];

    int   total = 0, bad = 0;
    int   cyc = 0, hs_cyc = -100, done_cyc = -100, hs_count = 0, wrun = 0;
    int   hang = 0, exp_cmds = 0;
    logic rst_seen = 1'b0, end_req = 1'b0, end_ack = 1'b0;
    rsp_t last_r = '{16'h0, 1'b0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d, dut%0d)", name, act, req, cyc, sel);
        end
    endtask

    always @(negedge clk) begin
        if (rst && rst_seen) begin
            chk("reset_ctrl", int'({m_ce_n, m_wr_n, m_rv, m_err, m_ready}), int'(5'b10000));
            chk("reset_data", int'({m_i, m_rd}), 0);
        end
        if (!rst && rst_seen)
            chk("ready_after_reset", int'(m_ready), 1);
        rst_seen = rst;

        if (cmd_valid && m_ready) begin
            hs_cyc = cyc;
            hs_count++;
        end
        if (cyc == hs_cyc + 1)
            chk("clear_on_accept", int'({m_rd, m_err}), 0);
        if (cyc == done_cyc + 1)
            chk("rsp_hold", int'({m_rd, m_err}), int'({last_r.d, last_r.e}));

        if (!m_ce_n && !m_wr_n) begin
            chk("word_queue_nonempty", int'(exp_w.size() > 0), 1);
            if (exp_w.size() > 0) chk("icap_word", int'(m_i), int'(exp_w.pop_front()));
        end
        if (m_ce_n)
            chk("idle_icap_i", int'(m_i), 0);

        if (rst) wrun = 0;
        else if (!m_ce_n && m_wr_n) wrun++;
        else if (wrun > 0) begin
            chk("wait_queue_nonempty", int'(exp_wait.size() > 0), 1);
            if (exp_wait.size() > 0) chk("rd_wait_cycles", wrun, exp_wait.pop_front());
            wrun = 0;
        end

        if (m_rv) begin
            chk("rsp_queue_nonempty", int'(exp_r.size() > 0), 1);
            if (exp_r.size() > 0) begin
                last_r = exp_r.pop_front();
                chk("rsp_data", int'(m_rd), int'(last_r.d));
                chk("rsp_err", int'(m_err), int'(last_r.e));
                chk("rsp_latency", cyc - hs_cyc, last_r.lat);
                done_cyc = cyc;
            end
        end

        if (end_req && !end_ack) begin
            chk("words_left", exp_w.size(), 0);
            chk("waits_left", exp_wait.size(), 0);
            chk("rsps_left", exp_r.size(), 0);
            chk("handshakes", hs_count, exp_cmds);
            chk("stim_timeouts", hang, 0);
            end_ack = 1'b1;
        end
    end

    function automatic logic [15:0] sw(input logic [15:0] w);
        logic [15:0] r;
        r = w;
        if (sel) for (int b = 0; b < 16; b++) r[b] = w[(b & 8) + 7 - (b & 7)];
        return r;
    endfunction

    task automatic push_sync();
        exp_w.push_back(sw(16'hFFFF));
        exp_w.push_back(sw(16'hAA99));
        exp_w.push_back(sw(16'h5566));
        exp_w.push_back(sw(16'h2000));
    endtask

    task automatic push_desync();
        exp_w.push_back(sw(16'h30A1));
        exp_w.push_back(sw(16'h000D));
        exp_w.push_back(sw(16'h2000));
        exp_w.push_back(sw(16'h2000));
    endtask

    task automatic exp_write(input logic [15:0] hdr, input logic [15:0] d);
        push_sync();
        exp_w.push_back(sw(hdr));
        exp_w.push_back(sw(d));
        exp_w.push_back(sw(16'h2000));
        exp_w.push_back(sw(16'h2000));
        push_desync();
        exp_r.push_back('{16'h0, 1'b0, 13});
        exp_cmds++;
    endtask

    task automatic exp_read(input logic [15:0] hdr, input int w, input logic [15:0] d, input logic e);
        push_sync();
        exp_w.push_back(sw(hdr));
        exp_w.push_back(sw(16'h2000));
        exp_w.push_back(sw(16'h2000));
        push_desync();
        exp_wait.push_back(w);
        exp_r.push_back('{d, e, 14 + w});
        exp_cmds++;
    endtask

    task automatic wait_rsp();
        int n = 0;
        @(negedge clk);
        while (!m_rv && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!m_rv) hang++;
    endtask

    task automatic start_cmd(input logic wr, input logic [5:0] a, input logic [15:0] d);
        int n = 0;
        @(posedge clk) #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_data = d;
        @(negedge clk);
        while (!m_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!m_ready) hang++;
        @(posedge clk) #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic wr, input logic [5:0] a, input logic [15:0] d,
                           input int busy_at, input logic [15:0] rv);
        busy_low_at = busy_at;
        rd_value    = rv;
        start_cmd(wr, a, d);
        wait_rsp();
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 6'd0;
        cmd_data = 16'd0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        exp_write(16'h30A1, 16'h000D);               run_cmd(1'b1, 6'h05, 16'h000D, 0, 16'h0);
        exp_read(16'h2AC1, 3, 16'h1234, 1'b0);       run_cmd(1'b0, 6'h16, 16'h0, 3, 16'h1234);
        exp_read(16'h2FE1, 2, 16'hABCD, 1'b0);       run_cmd(1'b0, 6'h3F, 16'h0, 1, 16'hABCD);
        exp_read(16'h2801, 8, 16'h0000, 1'b1);       run_cmd(1'b0, 6'h00, 16'h0, 0, 16'h5A5A);
        exp_write(16'h37E1, 16'hFFFF);               run_cmd(1'b1, 6'h3F, 16'hFFFF, 0, 16'h0);

        // valid held high across a whole command: second accept only after DONE
        exp_write(16'h3021, 16'h1234);
        exp_write(16'h3021, 16'h1234);
        @(posedge clk) #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h01; cmd_data = 16'h1234;
        wait_rsp();
        @(posedge clk);
        @(posedge clk) #1;
        cmd_valid = 1'b0;
        wait_rsp();

        // reset during the first NOOP word of a read
        push_sync();
        exp_w.push_back(16'h2841);
        exp_w.push_back(16'h2000);
        exp_cmds++;
        busy_low_at = 0;
        start_cmd(1'b0, 6'h02, 16'h0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_write(16'h30A1, 16'h00AA);               run_cmd(1'b1, 6'h05, 16'h00AA, 0, 16'h0);

        @(posedge clk) #1 sel = 1'b1;
        exp_write(16'h30A1, 16'h000D);               run_cmd(1'b1, 6'h05, 16'h000D, 0, 16'h0);
        exp_read(16'h2AC1, 3, 16'h0180, 1'b0);       run_cmd(1'b0, 6'h16, 16'h0, 3, 16'h8001);

        repeat (3) @(posedge clk);
        end_req = 1'b1;
        for (int n = 0; n < 10 && !end_ack; n++) @(posedge clk);
        if (!end_ack) $fatal(1, "FAIL end_of_test: monitor did not respond");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
